// File: rtl/ti_aes_pkg.sv
// ti_aes_pkg: shared types and normal-basis GF(2^4) helpers for the masked AES S-box datapath.
// gf16_mul is the tower multiply over GF(2^2); gf16_sqsc is the reference square-scaler.
package ti_aes_pkg;

  localparam int NSHARES_C = 3;

  typedef logic [3:0] nibble_t;
  typedef nibble_t [NSHARES_C-1:0] shares_t;

  function automatic logic [1:0] gf4_mul(input logic [1:0] x, input logic [1:0] y);
    logic e;
    e = (x[1] ^ x[0]) & (y[1] ^ y[0]);
    return {(x[1] & y[1]) ^ e, (x[0] & y[0]) ^ e};
  endfunction

  function automatic logic [1:0] gf4_scl_n(input logic [1:0] x);
    return {x[0], x[1] ^ x[0]};
  endfunction

  function automatic nibble_t gf16_mul(input nibble_t x, input nibble_t y);
    logic [1:0] e;
    e = gf4_scl_n(gf4_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]));
    return {gf4_mul(x[3:2], y[3:2]) ^ e, gf4_mul(x[1:0], y[1:0]) ^ e};
  endfunction

  function automatic nibble_t gf16_sqsc(input nibble_t d);
    return {d[0] ^ d[2], d[1] ^ d[3], d[1] ^ d[0], d[0]};
  endfunction

endpackage

// File: rtl/ti_inv_delta_comp.sv
// square_scaler and one non-complete Delta component: uses only shares a and b, never
// the share whose index the component carries.
module square_scaler (
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);
  assign o_q = {i_d[0] ^ i_d[2], i_d[1] ^ i_d[3], i_d[1] ^ i_d[0], i_d[0]};
endmodule

module ti_inv_delta_comp
  import ti_aes_pkg::*;
(
  input  logic [3:0] i_ah_a,
  input  logic [3:0] i_al_a,
  input  logic [3:0] i_ah_b,
  input  logic [3:0] i_al_b,
  output logic [3:0] o_delta
);
  logic [3:0] w_sum_a;
  logic [3:0] w_lin;

  assign w_sum_a = i_ah_a ^ i_al_a;

  square_scaler u_sqsc (
    .i_d (w_sum_a),
    .o_q (w_lin)
  );

  // Linear term of share a plus the three cross products that pair a with b.
  assign o_delta = w_lin
                 ^ gf16_mul(i_ah_a, i_al_a)
                 ^ gf16_mul(i_ah_a, i_al_b)
                 ^ gf16_mul(i_ah_b, i_al_a);
endmodule

// File: rtl/ti_inv_delta_stage.sv
// ti_inv_delta_stage: two-stage valid/ready TI pipeline emitting Delta shares plus aligned Ah/Al.
// Define TI_INV_DELTA_REMASK_EN to remask Delta with RandxDI on the stage-1 to stage-2 transfer.
module ti_inv_delta_stage
  import ti_aes_pkg::*;
#(
  parameter int NSHARES = NSHARES_C
) (
  input  logic                   ClkxCI,
  input  logic                   RstxRI,
  input  logic                   InValidxSI,
  output logic                   InReadyxSO,
  input  logic [4*NSHARES_C-1:0] AhxDI,
  input  logic [4*NSHARES_C-1:0] AlxDI,
  input  logic [7:0]             RandxDI,
  output logic                   OutValidxSO,
  input  logic                   OutReadyxSI,
  output logic [4*NSHARES_C-1:0] DeltaxDO,
  output logic [4*NSHARES_C-1:0] AhxDO,
  output logic [4*NSHARES_C-1:0] AlxDO
);

  if (NSHARES != NSHARES_C) begin : g_bad_nshares
    $error("ti_inv_delta_stage: only NSHARES = 3 is supported");
  end

  shares_t w_ah;
  shares_t w_al;
  shares_t w_delta;
  shares_t w_mask;
  logic    w_adv1;
  logic    w_adv2;

  logic    r_v1;
  logic    r_v2;
  shares_t r_delta1;
  shares_t r_ah1;
  shares_t r_al1;
  shares_t r_delta2;
  shares_t r_ah2;
  shares_t r_al2;

  assign w_ah = AhxDI;
  assign w_al = AlxDI;

  // Component gi sees only shares gi+1 and gi+2, which keeps it independent of share gi.
  genvar gi;
  generate
    for (gi = 0; gi < NSHARES_C; gi++) begin : g_comp
      ti_inv_delta_comp u_comp (
        .i_ah_a  (w_ah[(gi + 1) % NSHARES_C]),
        .i_al_a  (w_al[(gi + 1) % NSHARES_C]),
        .i_ah_b  (w_ah[(gi + 2) % NSHARES_C]),
        .i_al_b  (w_al[(gi + 2) % NSHARES_C]),
        .o_delta (w_delta[gi])
      );
    end
  endgenerate

`ifdef TI_INV_DELTA_REMASK_EN
  assign w_mask = {RandxDI[3:0] ^ RandxDI[7:4], RandxDI[7:4], RandxDI[3:0]};
`else
  logic w_unused_rand;
  assign w_unused_rand = ^RandxDI;
  assign w_mask        = '0;
`endif

  assign w_adv2     = !r_v2 || OutReadyxSI;
  assign w_adv1     = !r_v1 || w_adv2;
  assign InReadyxSO = w_adv1;

  // Stage 1 is the glitch barrier: the non-complete components settle here before recombining.
  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r_v1     <= 1'b0;
      r_delta1 <= '0;
      r_ah1    <= '0;
      r_al1    <= '0;
    end else begin
      if (w_adv1) begin
        r_v1 <= InValidxSI;
      end
      if (w_adv1 && InValidxSI) begin
        r_delta1 <= w_delta;
        r_ah1    <= w_ah;
        r_al1    <= w_al;
      end
    end
  end

  always_ff @(posedge ClkxCI or posedge RstxRI) begin
    if (RstxRI) begin
      r_v2     <= 1'b0;
      r_delta2 <= '0;
      r_ah2    <= '0;
      r_al2    <= '0;
    end else begin
      if (w_adv2) begin
        r_v2 <= r_v1;
      end
      if (w_adv2 && r_v1) begin
        r_delta2 <= r_delta1 ^ w_mask;
        r_ah2    <= r_ah1;
        r_al2    <= r_al1;
      end
    end
  end

  assign OutValidxSO = r_v2;
  assign DeltaxDO    = r_delta2;
  assign AhxDO       = r_ah2;
  assign AlxDO       = r_al2;

endmodule

// File: tb/tb_ti_inv_delta_stage.sv
// tb_ti_inv_delta_stage: directed vectors for the TI Delta stage with a small scoreboard;
// hand-computed Delta sums plus the package model for the exhaustive sweep.
module tb_ti_inv_delta_stage;
  import ti_aes_pkg::*;

  logic        ClkxCI = 1'b0;
  logic        RstxRI;
  logic        InValidxSI;
  logic        InReadyxSO;
  logic [11:0] AhxDI;
  logic [11:0] AlxDI;
  logic [7:0]  RandxDI;
  logic        OutValidxSO;
  logic        OutReadyxSI;
  logic [11:0] DeltaxDO;
  logic [11:0] AhxDO;
  logic [11:0] AlxDO;

  ti_inv_delta_stage #(.NSHARES(3)) dut (
    .ClkxCI      (ClkxCI),
    .RstxRI      (RstxRI),
    .InValidxSI  (InValidxSI),
    .InReadyxSO  (InReadyxSO),
    .AhxDI       (AhxDI),
    .AlxDI       (AlxDI),
    .RandxDI     (RandxDI),
    .OutValidxSO (OutValidxSO),
    .OutReadyxSI (OutReadyxSI),
    .DeltaxDO    (DeltaxDO),
    .AhxDO       (AhxDO),
    .AlxDO       (AlxDO)
  );

  always #5 ClkxCI = ~ClkxCI;

  typedef struct {
    logic [11:0] ah;
    logic [11:0] al;
    logic [3:0]  dsum;
    int          acc;
  } item_t;

  item_t      sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         cyc      = 0;
  int         n_out    = 0;
  bit         chk_lat  = 1'b1;
  logic [3:0] cur_exp  = 4'h0;

  function automatic logic [3:0] xor3(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

  function automatic logic [3:0] model(input logic [3:0] h, input logic [3:0] l);
    return gf16_sqsc(h ^ l) ^ gf16_mul(h, l);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Record handshakes just before the edge, then advance one clock.
  task automatic step();
    item_t it;
    #1;
    if (InValidxSI && InReadyxSO) begin
      it.ah   = AhxDI;
      it.al   = AlxDI;
      it.dsum = cur_exp;
      it.acc  = cyc;
      sb.push_back(it);
    end
    if (OutValidxSO && OutReadyxSI) begin
      if (sb.size() == 0) begin
        check("out_with_empty_sb", OutValidxSO, 1'b0);
      end else begin
        it = sb.pop_front();
        check("dsum", xor3(DeltaxDO), it.dsum);
        check("ah_out", AhxDO, it.ah);
        check("al_out", AlxDO, it.al);
        if (chk_lat) check("latency", cyc - it.acc, 2);
        n_out++;
        $display("txn %0d: ah=%h al=%h delta=%h dsum=%h", n_out, AhxDO, AlxDO, DeltaxDO, xor3(DeltaxDO));
      end
    end
    @(posedge ClkxCI);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic [3:0] h, input logic [3:0] l, input logic [3:0] e, input bit zm);
    logic [3:0] m1, m2, n1, n2;
    m1 = zm ? 4'h0 : 4'($urandom);
    m2 = zm ? 4'h0 : 4'($urandom);
    n1 = zm ? 4'h0 : 4'($urandom);
    n2 = zm ? 4'h0 : 4'($urandom);
    AhxDI      = {m2, m1, h ^ m1 ^ m2};
    AlxDI      = {n2, n1, l ^ n1 ^ n2};
    cur_exp    = e;
    InValidxSI = 1'b1;
  endtask

  task automatic send(input logic [3:0] h, input logic [3:0] l, input logic [3:0] e);
    drive(h, l, e, 1'b0);
    step();
  endtask

  task automatic drain(input int budget);
    InValidxSI = 1'b0;
    for (int k = 0; k < budget && sb.size() > 0; k++) step();
    check("drain_empty", sb.size(), 0);
  endtask

  task automatic run_one(input logic [11:0] ah, input logic [11:0] al, output logic [11:0] d);
    AhxDI      = ah;
    AlxDI      = al;
    cur_exp    = model(xor3(ah), xor3(al));
    InValidxSI = 1'b1;
    step();
    InValidxSI = 1'b0;
    step();
    check("one_valid", OutValidxSO, 1'b1);
    d = DeltaxDO;
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] d0, d1, base, sel, fa, fl;
    logic [35:0] snap;
    logic [7:0]  rv;
    logic [3:0]  m0, m1;
    int          n0;

    RstxRI      = 1'b1;
    InValidxSI  = 1'b0;
    OutReadyxSI = 1'b1;
    AhxDI       = '0;
    AlxDI       = '0;
    RandxDI     = '0;
    snap        = '0;

    repeat (3) @(posedge ClkxCI);
    #1;
    check("rst_valid", OutValidxSO, 1'b0);
    check("rst_delta", DeltaxDO, 12'h000);
    check("rst_ah", AhxDO, 12'h000);
    check("rst_al", AlxDO, 12'h000);
    RstxRI = 1'b0;
    #1;
    check("rst_inready", InReadyxSO, 1'b1);

    // Ah = 1, Al = 0, zero masks: Delta sum = SqSc(1) = 4'hB, two cycles after accept.
    drive(4'h1, 4'h0, 4'hB, 1'b1);
    step();
    InValidxSI = 1'b0;
    check("lat_early", OutValidxSO, 1'b0);
    step();
    check("lat_valid", OutValidxSO, 1'b1);
    check("first_dsum", xor3(DeltaxDO), 4'hB);
    step();

    // Hand-computed Delta sums with random masks, back to back.
    send(4'h1, 4'h1, 4'h7);
    send(4'h2, 4'h3, 4'hC);
    send(4'hF, 4'hF, 4'hF);
    send(4'h4, 4'h8, 4'hA);
    send(4'h0, 4'h0, 4'h0);
    drain(10);

    // Ah = Al = 0 with random masks.
    for (int t = 0; t < 1000; t++) send(4'h0, 4'h0, 4'h0);
    drain(10);

    // Exhaustive (Ah, Al) sweep, one item per cycle.
    n0 = n_out;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        send(4'(a), 4'(b), model(4'(a), 4'(b)));
    drain(10);
    check("sweep_count", n_out - n0, 256);

    // Delta share i must not move when only input share i changes.
    fa      = 12'h5C3;
    fl      = 12'hA96;
    RandxDI = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      sel = 12'hF << (4 * i);
      run_one(fa, fl, d0);
      run_one(fa ^ (sel & 12'h7A5), fl ^ (sel & 12'h7A5), d1);
      check("noncomplete", d1[4*i +: 4], d0[4*i +: 4]);
    end

    // RandxDI sweep with fixed input and masks.
    RandxDI = 8'h00;
    run_one(fa, fl, base);
    for (int r = 1; r < 256; r++) begin
      rv      = 8'(r);
      RandxDI = rv;
      run_one(fa, fl, d1);
`ifdef TI_INV_DELTA_REMASK_EN
      m0 = rv[3:0];
      m1 = rv[7:4];
`else
      m0 = 4'h0;
      m1 = 4'h0;
`endif
      check("remask_d1", d1[3:0], base[3:0] ^ m0);
      check("remask_d2", d1[7:4], base[7:4] ^ m1);
      check("remask_d3", d1[11:8], base[11:8] ^ m0 ^ m1);
    end
    RandxDI = 8'h00;

    // Backpressure: five stalled cycles with a continuous valid input.
    chk_lat     = 1'b0;
    OutReadyxSI = 1'b0;
    n0          = n_out;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) drive(4'(k + 3), 4'(k + 5), model(4'(k + 3), 4'(k + 5)), 1'b0);
      #1;
      check("bp_inready", InReadyxSO, (k < 2));
      if (k >= 2) begin
        check("bp_valid", OutValidxSO, 1'b1);
        if (k == 2) snap = {DeltaxDO, AhxDO, AlxDO};
        else check("bp_stable", {DeltaxDO, AhxDO, AlxDO}, snap);
      end
      step();
    end
    check("bp_buffered", sb.size(), 2);
    OutReadyxSI = 1'b1;
    step();
    drain(10);
    check("bp_count", n_out - n0, 3);
    chk_lat = 1'b1;

    // Asynchronous reset with both stages full.
    OutReadyxSI = 1'b0;
    drive(4'h6, 4'h9, model(4'h6, 4'h9), 1'b0);
    step();
    drive(4'hA, 4'h3, model(4'hA, 4'h3), 1'b0);
    step();
    InValidxSI = 1'b0;
    check("full_valid", OutValidxSO, 1'b1);
    #2;
    RstxRI = 1'b1;
    #1;
    check("arst_valid", OutValidxSO, 1'b0);
    check("arst_delta", DeltaxDO, 12'h000);
    check("arst_ah", AhxDO, 12'h000);
    check("arst_al", AlxDO, 12'h000);
    sb.delete();
    @(posedge ClkxCI);
    #3;
    RstxRI = 1'b0;
    @(posedge ClkxCI);
    #1;
    check("post_rst_inready", InReadyxSO, 1'b1);
    check("post_rst_valid", OutValidxSO, 1'b0);
    OutReadyxSI = 1'b1;
    send(4'h1, 4'h0, 4'hB);
    drain(10);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
